// File: rtl/mod_counter_n.sv
// Modulo-N up/down counter with clamped parallel load and cascadable RCO.
// Optional capture register enabled by MOD_COUNTER_CAPTURE_EN.
module mod_counter_n #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
`ifdef MOD_COUNTER_CAPTURE_EN
  input  logic             CAP,
  output logic [WIDTH-1:0] CAPQ,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   L_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == L_MAX);
  assign w_at_zero = (r_q == '0);

  // Out-of-range loads saturate so Q never leaves 0..MODULUS-1
  assign w_load = ({1'b0, D} < L_MOD) ? D : L_MAX;
  assign w_inc  = w_at_max  ? '0    : r_q + 1'b1;
  assign w_dec  = w_at_zero ? L_MAX : r_q - 1'b1;

  always_ff @(posedge CLK) begin
    if (CLR)
      r_q <= '0;
    else if (!LOAD_n)
      r_q <= w_load;
    else if (ENP && ENT)
      r_q <= UP ? w_inc : w_dec;
  end

  assign Q   = r_q;
  assign RCO = ENT & (UP ? w_at_max : w_at_zero);

`ifdef MOD_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] r_capq;

  // Captures the pre-edge count, before any load or count takes effect
  always_ff @(posedge CLK) begin
    if (CLR)
      r_capq <= '0;
    else if (CAP)
      r_capq <= r_q;
  end

  assign CAPQ = r_capq;
`endif

endmodule

// File: tb/tb_mod_counter_n.sv
// Self-checking bench for mod_counter_n: directed plan steps plus
// randomized traffic against an arithmetic reference model.
module tb_mod_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: WIDTH=4, MODULUS=10
  logic       clr, ld_n, enp, ent, up;
  logic [3:0] d, q;
  logic       rco;
  int         mq;

  // Cascade pair: decade units driving decade tens
  logic       c_clr, c_enp, c_ent;
  logic [3:0] lo_q, hi_q, c_d;
  logic       lo_rco, hi_rco;
  int         mcnt;

  // Full-binary instance: WIDTH=8, MODULUS=256
  logic       w_clr, w_ld_n, w_enp, w_ent, w_up, w_cap;
  logic [7:0] w_d, w_q;
  logic       w_rco;
  int         wq;
  int         mcap;

`ifdef MOD_COUNTER_CAPTURE_EN
  logic [3:0] dut_capq, lo_capq, hi_capq;
  logic [7:0] w_capq;
`endif

  mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_dut (
    .CLK(clk), .CLR(clr), .D(d), .LOAD_n(ld_n),
    .ENP(enp), .ENT(ent), .UP(up),
`ifdef MOD_COUNTER_CAPTURE_EN
    .CAP(1'b0), .CAPQ(dut_capq),
`endif
    .Q(q), .RCO(rco)
  );

  mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CLK(clk), .CLR(c_clr), .D(c_d), .LOAD_n(1'b1),
    .ENP(c_enp), .ENT(c_ent), .UP(1'b1),
`ifdef MOD_COUNTER_CAPTURE_EN
    .CAP(1'b0), .CAPQ(lo_capq),
`endif
    .Q(lo_q), .RCO(lo_rco)
  );

  mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CLK(clk), .CLR(c_clr), .D(c_d), .LOAD_n(1'b1),
    .ENP(c_enp), .ENT(lo_rco), .UP(1'b1),
`ifdef MOD_COUNTER_CAPTURE_EN
    .CAP(1'b0), .CAPQ(hi_capq),
`endif
    .Q(hi_q), .RCO(hi_rco)
  );

  mod_counter_n #(.WIDTH(8), .MODULUS(256)) u_wide (
    .CLK(clk), .CLR(w_clr), .D(w_d), .LOAD_n(w_ld_n),
    .ENP(w_enp), .ENT(w_ent), .UP(w_up),
`ifdef MOD_COUNTER_CAPTURE_EN
    .CAP(w_cap), .CAPQ(w_capq),
`endif
    .Q(w_q), .RCO(w_rco)
  );

  function automatic int mnext(int cur, bit c, bit l_n, int dv,
                               bit p, bit t, bit u, int m);
    if (c) return 0;
    if (!l_n) return (dv < m) ? dv : m - 1;
    if (p && t) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  function automatic bit mrco(int cur, bit t, bit u, int m);
    return t && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance models with pre-edge inputs, then let the edge happen
  task automatic tick();
    mcap = w_clr ? 0 : (w_cap ? wq : mcap);
    mq   = mnext(mq, clr, ld_n, int'(d), enp, ent, up, 10);
    wq   = mnext(wq, w_clr, w_ld_n, int'(w_d), w_enp, w_ent, w_up, 256);
    if (c_clr) mcnt = 0;
    else if (c_enp && c_ent) mcnt = (mcnt + 1) % 100;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_q"},    int'(q),      mq);
    chk({tag, "_rco"},  int'(rco),    int'(mrco(mq, ent, up, 10)));
    chk({tag, "_lo"},   int'(lo_q),   mcnt % 10);
    chk({tag, "_hi"},   int'(hi_q),   mcnt / 10);
    chk({tag, "_hrco"}, int'(hi_rco), int'(c_ent && mcnt == 99));
    chk({tag, "_wq"},   int'(w_q),    wq);
    chk({tag, "_wrco"}, int'(w_rco),  int'(mrco(wq, w_ent, w_up, 256)));
`ifdef MOD_COUNTER_CAPTURE_EN
    chk({tag, "_capq"}, int'(w_capq), mcap);
`endif
  endtask

  initial begin
    mq = 0; wq = 0; mcnt = 0; mcap = 0;
    clr = 1; ld_n = 1; enp = 0; ent = 0; up = 1; d = 0;
    c_clr = 1; c_enp = 0; c_ent = 0; c_d = 0;
    w_clr = 1; w_ld_n = 1; w_enp = 0; w_ent = 0; w_up = 1;
    w_d = 0; w_cap = 0;
    tick();
    check_all("init");

    // Reset beats a simultaneous load
    clr = 0; ld_n = 0; d = 7;
    tick();
    chk("load7", int'(q), 7);
    clr = 1; d = 3;
    tick();
    chk("clr_over_load", int'(q), 0);
    clr = 0; ld_n = 1; ent = 1; up = 0;
    #1;
    chk("rco_reset_down", int'(rco), 1);
    check_all("reset");

    // Up wrap 1..9,0
    up = 1; enp = 1; ent = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("upwrap_seq", int'(q), (i + 1) % 10);
      chk("upwrap_rco", int'(rco), int'(i == 8));
      check_all("upwrap");
    end

    // Load clamp then down wrap 8..0,9
    ld_n = 0; d = 12;
    tick();
    chk("clamp", int'(q), 9);
    ld_n = 1; up = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dnwrap_seq", int'(q), (i == 9) ? 9 : 8 - i);
      chk("dnwrap_rco", int'(rco), int'(i == 8));
      check_all("dnwrap");
    end

    // Enables and load priority
    up = 1; enp = 0; ent = 1;
    tick();
    chk("hold_q", int'(q), 9);
    chk("hold_rco", int'(rco), 1);
    ent = 0;
    #1;
    chk("ent0_rco", int'(rco), 0);
    ld_n = 0; d = 4; enp = 1; ent = 1;
    tick();
    chk("load_wins", int'(q), 4);
    ld_n = 1;
    check_all("prio");

    // Cascade: 25 enabled edges from 00
    c_clr = 0; c_enp = 1; c_ent = 1;
    repeat (25) begin
      tick();
      check_all("casc");
    end
    chk("casc_hi", int'(hi_q), 2);
    chk("casc_lo", int'(lo_q), 5);

    // Full-binary wrap with capture at Q=255
    w_clr = 0; w_ld_n = 0; w_d = 8'd254;
    tick();
    w_ld_n = 1; w_enp = 1; w_ent = 1; w_up = 1;
    tick();
    chk("wide_255", int'(w_q), 255);
    chk("wide_rco", int'(w_rco), 1);
    w_cap = 1;
    tick();
    chk("wide_wrap", int'(w_q), 0);
`ifdef MOD_COUNTER_CAPTURE_EN
    chk("cap_255", int'(w_capq), 255);
`endif
    w_clr = 1;
    tick();
`ifdef MOD_COUNTER_CAPTURE_EN
    chk("cap_clr", int'(w_capq), 0);
`endif
    w_cap = 0; w_clr = 0;
    check_all("wide");

    // Randomized traffic on all instances
    for (int i = 0; i < 400; i++) begin
      clr    = ($urandom_range(0, 31) == 0);
      ld_n   = ($urandom_range(0, 7) != 0);
      d      = 4'($urandom_range(0, 15));
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom_range(0, 1));
      c_clr  = ($urandom_range(0, 63) == 0);
      c_enp  = ($urandom_range(0, 3) != 0);
      c_ent  = ($urandom_range(0, 3) != 0);
      w_clr  = ($urandom_range(0, 31) == 0);
      w_ld_n = ($urandom_range(0, 7) != 0);
      w_d    = 8'($urandom_range(0, 255));
      w_enp  = ($urandom_range(0, 3) != 0);
      w_ent  = ($urandom_range(0, 3) != 0);
      w_up   = 1'($urandom_range(0, 1));
      w_cap  = 1'($urandom_range(0, 1));
      #1;
      check_all("rnd_pre");
      tick();
      check_all("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
